uart_alu_host: RTL
==================

# uart_alu_host

Host-side initiator for the UART ALU link. It sends one command, waits for the one-byte result, and reports it. It serializes a three-byte command frame (operand A, operand B, operation code) onto a UART line, then deserializes the result byte the ALU side returns. It uses the same oversampling tick as the rest of the UART path and drives the ALU-side receive pin directly. It is used both as the bench driver for the full UART-ALU system and as the FPGA-side master when two boards are linked.

## Interface
Parameters:
- NB_DATA, 8, bits per UART data byte and per operand/result
- NB_OP, 6, operation code width; zero-extended to NB_DATA on the wire
- NB_STOP, 16, ticks per stop bit
- TIMEOUT_TICKS, 4096, ticks allowed in the response wait before abort
- NB_TIMEOUT, 13, width of the timeout counter

Ports:
- clk  in  1  system clock; only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_tick  in  1  one-cycle pulse at 16x baud
- i_start  in  1  request a transaction; sampled only in IDLE
- i_datoA  in  NB_DATA  operand A
- i_datoB  in  NB_DATA  operand B
- i_operation  in  NB_OP  operation code
- i_rx  in  1  serial line from the ALU side
- o_tx  out  1  serial line to the ALU side; idles high
- o_busy  out  1  high from start accept until done
- o_done  out  1  one-cycle pulse when a transaction ends, on success or failure
- o_result  out  NB_DATA  last good result; held between transactions
- o_timeout  out  1  qualifies o_done: no response within TIMEOUT_TICKS
- o_frame_err  out  1  qualifies o_done: response stop bit sampled low

## Operation
- Top FSM has four states: IDLE, SEND, WAIT_RX, DONE.
- IDLE → SEND:
  - Occurs on i_start=1.
  - i_datoA, i_datoB and {0, i_operation} are latched into a 3-entry byte buffer.
  - o_busy rises on the next cycle.
- SEND:
  - Bytes are transmitted in order: A, then B, then op.
  - Each byte is 1 start bit (0), NB_DATA data bits LSB first, and 1 stop bit (1).
  - Start and data bits last 16 ticks each; the stop bit lasts NB_STOP ticks.
  - The next byte's start bit begins on the tick after the previous stop bit ends, with no idle gap.
  - After the third stop bit completes, the FSM goes to WAIT_RX.
- WAIT_RX:
  - The receiver is armed and the timeout counter is cleared.
  - The timeout counter increments on each tick until a start edge is detected.
  - A start edge is i_rx going from 1 to 0, synchronized through a 2-flop synchronizer.
  - The start bit is confirmed by sampling low at tick 7; a high sample returns the receiver to hunting.
  - Data bits are sampled every 16 ticks thereafter, LSB first.
  - The stop bit is sampled 16 ticks after the last data bit.
  - The counter reaching TIMEOUT_TICKS−1 with no start edge goes to DONE with o_timeout=1.
- DONE (one cycle):
  - o_done=1; o_busy falls on the next cycle; the FSM returns to IDLE.
  - On a good stop bit, o_result ← received byte.
  - On a bad stop bit, o_frame_err=1 and o_result is unchanged.
- The receiver ignores i_rx outside WAIT_RX. i_start outside IDLE is ignored and not queued.
- o_timeout and o_frame_err are valid only in the o_done cycle and are 0 otherwise.

## Timing
- Reset values:
  - o_tx=1, o_busy=0, o_done=0, o_result=0, o_timeout=0, o_frame_err=0.
  - All counters are 0 and the FSM is in IDLE.
- Reset is asynchronous. Asserting it mid-frame forces o_tx=1 immediately. No partial byte is resumed after release.
- Start latency: the start bit (o_tx=0) appears on the first i_tick after the accept cycle.
- Command duration: 3 × (10 bits × 16 ticks) = 480 ticks with NB_STOP=16.
- Response to done: o_done follows the stop-bit sample tick by 1 clk.
- Tick counters wrap at 15 within a bit. The data-bit index counts 0..NB_DATA−1. The byte index counts 0..2 and does not wrap; it is cleared in IDLE.
- Simultaneous events:
  - An i_start in the same cycle as o_done is ignored, because the FSM is not in IDLE.
  - An i_tick in the accept cycle is not counted.
  - A start edge on the same tick the timeout would fire: the edge wins.

## Test plan
- A=0x05, B=0x03, op=0x20, with a bench responder returning 0x08:
  - o_tx shows bytes 0x05, 0x03, 0x20, each with correct 16-tick bits.
  - o_done pulses with o_result=0x08 and both error flags 0.
- Responder silent after the command:
  - Exactly TIMEOUT_TICKS ticks after the third stop bit, o_done=1 and o_timeout=1.
  - o_result keeps its previous value.
- Responder sends 0x5A with the stop bit forced to 0:
  - o_done=1 and o_frame_err=1.
  - o_result is unchanged.
- A 3-tick low glitch on i_rx during WAIT_RX, followed by a valid 0xC3 frame: the glitch is rejected and o_result=0xC3.
- i_start pulsed mid-SEND: no second transaction occurs, and exactly one o_done is seen.
- i_rst_n asserted while the second byte's data bits are being sent:
  - o_tx=1 and o_busy=0 at once.
  - A new i_start after release sends a complete fresh frame beginning with A.

Source files
------------

// File: rtl/uart_alu_host.sv
// uart_alu_host
// Host-side initiator for the UART ALU link. On a start request it latches
// operand A, operand B and the zero-extended operation code, serializes them
// as three back-to-back 8N1 bytes on o_tx, then waits for the single result
// byte coming back on i_rx and reports it with a one-cycle o_done pulse.
//
// Ports:
//   clk          system clock
//   i_rst_n      asynchronous active-low reset
//   i_tick       one-cycle pulse at 16x baud
//   i_start      transaction request, honoured only while idle
//   i_datoA/B    operands
//   i_operation  operation code (zero-extended to NB_DATA on the wire)
//   i_rx         serial line from the ALU side
//   o_tx         serial line to the ALU side, idles high
//   o_busy       high from start accept until the transaction ends
//   o_done       one-cycle end-of-transaction pulse
//   o_result     last good result byte, held between transactions
//   o_timeout    with o_done: no response arrived in time
//   o_frame_err  with o_done: response stop bit sampled low
module uart_alu_host #(
    parameter int NB_DATA       = 8,
    parameter int NB_OP         = 6,
    parameter int NB_STOP       = 16,
    parameter int TIMEOUT_TICKS = 4096,
    parameter int NB_TIMEOUT    = 13
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_datoA,
    input  logic [NB_DATA-1:0] i_datoB,
    input  logic [NB_OP-1:0]   i_operation,
    input  logic               i_rx,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_timeout,
    output logic               o_frame_err
);

    // The transmit tick counter must also cover a stop bit of NB_STOP ticks.
    localparam int NB_TCNT = ($clog2(NB_STOP) > 4) ? $clog2(NB_STOP) : 4;
    localparam int NB_BIDX = $clog2(NB_DATA);

    localparam logic [NB_TCNT-1:0]    TX_BIT_LAST  = NB_TCNT'(15);
    localparam logic [NB_TCNT-1:0]    TX_STOP_LAST = NB_TCNT'(NB_STOP - 1);
    localparam logic [NB_BIDX-1:0]    BIDX_LAST    = NB_BIDX'(NB_DATA - 1);
    localparam logic [NB_TIMEOUT-1:0] TO_LAST      = NB_TIMEOUT'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]            RX_MID       = 4'd7;
    localparam logic [3:0]            RX_BIT_LAST  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_RX = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TX_WAIT  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_phase_t;

    typedef enum logic [1:0] {
        RX_HUNT  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_phase_t;

    // Pick one of the three latched command bytes by index.
    function automatic logic [NB_DATA-1:0] sel_byte(
        input logic [1:0]         idx,
        input logic [NB_DATA-1:0] a,
        input logic [NB_DATA-1:0] b,
        input logic [NB_DATA-1:0] op
    );
        logic [NB_DATA-1:0] r;
        case (idx)
            2'd0:    r = a;
            2'd1:    r = b;
            2'd2:    r = op;
            default: r = {NB_DATA{1'b0}};
        endcase
        return r;
    endfunction

    state_t             state_r, state_next_s;
    logic [NB_DATA-1:0] cmd_a_r, cmd_b_r, cmd_op_r;
    logic [1:0]         byte_idx_r;
    tx_phase_t          tx_phase_r;
    logic [NB_TCNT-1:0] tx_cnt_r;
    logic [NB_BIDX-1:0] tx_bit_r;
    logic [NB_DATA-1:0] tx_shift_r;
    logic               tx_r;

    logic               rx_sync1_r, rx_sync2_r, rx_prev_r;
    rx_phase_t          rx_phase_r;
    logic [3:0]         rx_cnt_r;
    logic [NB_BIDX-1:0] rx_bit_r;
    logic [NB_DATA-1:0] rx_shift_r;
    logic [NB_TIMEOUT-1:0] to_cnt_r;

    logic               busy_r, done_r, timeout_r, frame_err_r;
    logic [NB_DATA-1:0] result_r;

    logic               accept_s, tx_end_s, rx_edge_s, rx_stop_s, to_fire_s;
    logic [NB_DATA-1:0] next_byte_s;

    assign accept_s  = (state_r == ST_IDLE) && i_start;
    assign tx_end_s  = (state_r == ST_SEND) && i_tick && (tx_phase_r == TX_STOP)
                       && (tx_cnt_r == TX_STOP_LAST) && (byte_idx_r == 2'd2);
    assign rx_edge_s = (state_r == ST_WAIT_RX) && (rx_phase_r == RX_HUNT)
                       && rx_prev_r && !rx_sync2_r;
    assign rx_stop_s = (state_r == ST_WAIT_RX) && i_tick && (rx_phase_r == RX_STOP)
                       && (rx_cnt_r == RX_BIT_LAST);
    // A start edge arriving on the expiry tick takes priority over the timeout.
    assign to_fire_s = (state_r == ST_WAIT_RX) && (rx_phase_r == RX_HUNT) && i_tick
                       && !rx_edge_s && (to_cnt_r == TO_LAST);
    assign next_byte_s = sel_byte(byte_idx_r + 2'd1, cmd_a_r, cmd_b_r, cmd_op_r);

    // Top FSM state register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Top FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_SEND;
                else          state_next_s = ST_IDLE;
            end
            ST_SEND: begin
                if (tx_end_s) state_next_s = ST_WAIT_RX;
                else          state_next_s = ST_SEND;
            end
            ST_WAIT_RX: begin
                if (rx_stop_s || to_fire_s) state_next_s = ST_DONE;
                else                        state_next_s = ST_WAIT_RX;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Command latch and serializer; the first start bit waits for a tick after accept.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_a_r    <= {NB_DATA{1'b0}};
            cmd_b_r    <= {NB_DATA{1'b0}};
            cmd_op_r   <= {NB_DATA{1'b0}};
            byte_idx_r <= 2'd0;
            tx_phase_r <= TX_WAIT;
            tx_cnt_r   <= {NB_TCNT{1'b0}};
            tx_bit_r   <= {NB_BIDX{1'b0}};
            tx_shift_r <= {NB_DATA{1'b0}};
            tx_r       <= 1'b1;
        end else if (accept_s) begin
            cmd_a_r    <= i_datoA;
            cmd_b_r    <= i_datoB;
            cmd_op_r   <= {{(NB_DATA-NB_OP){1'b0}}, i_operation};
            byte_idx_r <= 2'd0;
            tx_phase_r <= TX_WAIT;
            tx_cnt_r   <= {NB_TCNT{1'b0}};
            tx_bit_r   <= {NB_BIDX{1'b0}};
            tx_r       <= 1'b1;
        end else if ((state_r == ST_SEND) && i_tick) begin
            case (tx_phase_r)
                TX_WAIT: begin
                    tx_r       <= 1'b0;
                    tx_shift_r <= cmd_a_r;
                    tx_cnt_r   <= {NB_TCNT{1'b0}};
                    tx_phase_r <= TX_START;
                end
                TX_START: begin
                    if (tx_cnt_r == TX_BIT_LAST) begin
                        tx_r       <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[NB_DATA-1:1]};
                        tx_bit_r   <= {NB_BIDX{1'b0}};
                        tx_cnt_r   <= {NB_TCNT{1'b0}};
                        tx_phase_r <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + NB_TCNT'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == TX_BIT_LAST) begin
                        tx_cnt_r <= {NB_TCNT{1'b0}};
                        if (tx_bit_r == BIDX_LAST) begin
                            tx_r       <= 1'b1;
                            tx_phase_r <= TX_STOP;
                        end else begin
                            tx_r       <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[NB_DATA-1:1]};
                            tx_bit_r   <= tx_bit_r + NB_BIDX'(1);
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + NB_TCNT'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == TX_STOP_LAST) begin
                        tx_cnt_r <= {NB_TCNT{1'b0}};
                        if (byte_idx_r == 2'd2) begin
                            tx_phase_r <= TX_WAIT;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            byte_idx_r <= byte_idx_r + 2'd1;
                            tx_r       <= 1'b0;
                            tx_shift_r <= next_byte_s;
                            tx_phase_r <= TX_START;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + NB_TCNT'(1);
                    end
                end
                default: begin
                    tx_r       <= 1'b1;
                    tx_phase_r <= TX_WAIT;
                end
            endcase
        end else if (state_r == ST_IDLE) begin
            byte_idx_r <= 2'd0;
            tx_r       <= 1'b1;
        end
    end

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_prev_r  <= 1'b1;
        end else begin
            rx_sync1_r <= i_rx;
            rx_sync2_r <= rx_sync1_r;
            rx_prev_r  <= rx_sync2_r;
        end
    end

    // Response receiver and timeout counter; held cleared outside WAIT_RX.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_phase_r <= RX_HUNT;
            rx_cnt_r   <= 4'd0;
            rx_bit_r   <= {NB_BIDX{1'b0}};
            rx_shift_r <= {NB_DATA{1'b0}};
            to_cnt_r   <= {NB_TIMEOUT{1'b0}};
        end else if (state_r != ST_WAIT_RX) begin
            rx_phase_r <= RX_HUNT;
            rx_cnt_r   <= 4'd0;
            rx_bit_r   <= {NB_BIDX{1'b0}};
            to_cnt_r   <= {NB_TIMEOUT{1'b0}};
        end else begin
            case (rx_phase_r)
                RX_HUNT: begin
                    if (rx_edge_s) begin
                        rx_cnt_r   <= 4'd0;
                        rx_phase_r <= RX_START;
                    end else if (i_tick) begin
                        to_cnt_r <= to_cnt_r + NB_TIMEOUT'(1);
                    end
                end
                RX_START: begin
                    if (i_tick) begin
                        if (rx_cnt_r == RX_MID) begin
                            rx_cnt_r <= 4'd0;
                            rx_bit_r <= {NB_BIDX{1'b0}};
                            // A line already back high was a glitch, not a start bit.
                            if (!rx_sync2_r) rx_phase_r <= RX_DATA;
                            else             rx_phase_r <= RX_HUNT;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (i_tick) begin
                        if (rx_cnt_r == RX_BIT_LAST) begin
                            rx_cnt_r   <= 4'd0;
                            rx_shift_r <= {rx_sync2_r, rx_shift_r[NB_DATA-1:1]};
                            if (rx_bit_r == BIDX_LAST) rx_phase_r <= RX_STOP;
                            else                       rx_bit_r   <= rx_bit_r + NB_BIDX'(1);
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (i_tick) begin
                        if (rx_cnt_r == RX_BIT_LAST) begin
                            rx_cnt_r   <= 4'd0;
                            rx_phase_r <= RX_HUNT;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                default: rx_phase_r <= RX_HUNT;
            endcase
        end
    end

    // Status outputs; error flags live only in the o_done cycle.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            frame_err_r <= 1'b0;
            result_r    <= {NB_DATA{1'b0}};
        end else begin
            if (accept_s)                busy_r <= 1'b1;
            else if (state_r == ST_DONE) busy_r <= 1'b0;
            done_r      <= rx_stop_s | to_fire_s;
            timeout_r   <= to_fire_s;
            frame_err_r <= rx_stop_s & ~rx_sync2_r;
            if (rx_stop_s && rx_sync2_r) result_r <= rx_shift_r;
        end
    end

    assign o_tx        = tx_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_result    = result_r;
    assign o_timeout   = timeout_r;
    assign o_frame_err = frame_err_r;

endmodule
